// File: rtl/memory_access_width.sv
// Shared access-width encoding for the data memory and every block that talks to it.
package memory_access_width;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } memory_access_width_t;

   function automatic logic [2:0] memory_access_width_to_bytes(memory_access_width_t w);
      case (w)
         BYTE:    return 3'd1;
         HALF:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/memory_arbiter_pkg.sv
// Types shared by the memory arbiter, its sub-module and its interface.
package memory_arbiter_pkg;
   import memory_access_width::*;

   typedef enum logic {
      IF = 1'b0,
      LS = 1'b1
   } mem_requester_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } mem_arb_state_t;

   // Keeps only the bytes an access of this width actually returned.
   function automatic logic [31:0] width_mask(memory_access_width_t w);
      case (w)
         BYTE:    return 32'h0000_00FF;
         HALF:    return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Request/response channels of both requesters plus the memory port.
// The slave modport is the arbiter's view; master is the surrounding core and memory.
interface memory_arbiter_if
   import memory_access_width::*;
#(
   parameter int ADDR_W = 32
) ();

   logic                 if_req_valid;
   logic                 if_req_ready;
   logic [ADDR_W-1:0]    if_req_addr;
   logic                 if_rsp_valid;
   logic [31:0]          if_rsp_data;
   logic                 if_rsp_err;

   logic                 ls_req_valid;
   logic                 ls_req_ready;
   logic [ADDR_W-1:0]    ls_req_addr;
   logic                 ls_req_write;
   memory_access_width_t ls_req_width;
   logic [31:0]          ls_req_data;
   logic                 ls_rsp_valid;
   logic [31:0]          ls_rsp_data;
   logic                 ls_rsp_err;

   logic [ADDR_W-1:0]    mem_addr;
   memory_access_width_t mem_width;
   logic                 mem_rd_en;
   logic                 mem_wr_en;
   logic [31:0]          mem_data_wr;
   logic [31:0]          mem_data_rd;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  ls_req_valid, ls_req_addr, ls_req_write, ls_req_width, ls_req_data,
      output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      output mem_addr, mem_width, mem_rd_en, mem_wr_en, mem_data_wr,
      input  mem_data_rd
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output ls_req_valid, ls_req_addr, ls_req_write, ls_req_width, ls_req_data,
      input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      input  mem_addr, mem_width, mem_rd_en, mem_wr_en, mem_data_wr,
      output mem_data_rd
   );

endinterface

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to whoever was not granted last.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last_gnt)) begin
         gnt[0] = 1'b1;
      end else if (req[1]) begin
         gnt[1] = 1'b1;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates fetch and load/store requests onto the single-port data memory,
// one access every two cycles, with a registered response to the granted side.
module memory_arbiter
   import memory_access_width::*;
   import memory_arbiter_pkg::*;
#(
   parameter int BYTES  = 64000,
   parameter int ADDR_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   memory_arbiter_if.slave  bus
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(BYTES);

   mem_arb_state_t       state_q, state_d;
   mem_requester_t       last_grant_q, src_q, accept_src;
   logic [ADDR_W-1:0]    addr_q;
   memory_access_width_t width_q;
   logic                 write_q;
   logic [31:0]          wdata_q;
   logic [31:0]          rsp_data_q;
   logic                 rsp_err_q;

   logic [1:0]           grant;
   logic                 can_accept, accept;
   logic [ADDR_W:0]      end_addr;
   logic                 range_err, access_ok, rsp_live;

   rr_arbiter2 u_rr (
      .req      ({bus.ls_req_valid, bus.if_req_valid}),
      .last_gnt (last_grant_q == LS),
      .gnt      (grant)
   );

   // One extra bit so an address that wraps past the top of the space is caught too.
   assign end_addr   = {1'b0, addr_q} + (ADDR_W+1)'(memory_access_width_to_bytes(width_q));
   assign range_err  = end_addr > LIMIT;
   assign can_accept = rst_n && (state_q == IDLE || state_q == RESPOND);
   assign accept     = can_accept && (grant != 2'b00);
   assign accept_src = grant[1] ? LS : IF;
   assign access_ok  = rst_n && state_q == ACCESS && !range_err;
   assign rsp_live   = rst_n && state_q == RESPOND;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Everything leaving the block is gated by rst_n so reset silences it immediately.
   always_comb begin
      state_d          = state_q;
      bus.if_req_ready = can_accept && grant[0];
      bus.ls_req_ready = can_accept && grant[1];
      bus.mem_rd_en    = access_ok && !write_q;
      bus.mem_wr_en    = access_ok && write_q;
      bus.mem_addr     = access_ok ? addr_q : '0;
      bus.mem_width    = access_ok ? width_q : BYTE;
      bus.mem_data_wr  = access_ok ? wdata_q : '0;
      bus.if_rsp_valid = rsp_live && src_q == IF;
      bus.ls_rsp_valid = rsp_live && src_q == LS;
      bus.if_rsp_data  = bus.if_rsp_valid ? rsp_data_q : '0;
      bus.if_rsp_err   = bus.if_rsp_valid && rsp_err_q;
      bus.ls_rsp_data  = bus.ls_rsp_valid ? rsp_data_q : '0;
      bus.ls_rsp_err   = bus.ls_rsp_valid && rsp_err_q;
      case (state_q)
         IDLE, RESPOND: state_d = accept ? ACCESS : IDLE;
         ACCESS:        state_d = RESPOND;
         default:       state_d = IDLE;
      endcase
   end

   // The payload is sampled only on the accept edge; the response only in ACCESS.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= LS;
         src_q        <= IF;
         addr_q       <= '0;
         width_q      <= BYTE;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         if (accept) begin
            src_q        <= accept_src;
            last_grant_q <= accept_src;
            if (accept_src == LS) begin
               addr_q  <= bus.ls_req_addr;
               width_q <= bus.ls_req_width;
               write_q <= bus.ls_req_write;
               wdata_q <= bus.ls_req_data;
            end else begin
               addr_q  <= bus.if_req_addr;
               width_q <= WORD;
               write_q <= 1'b0;
               wdata_q <= '0;
            end
         end
         if (state_q == ACCESS) begin
            rsp_err_q  <= range_err;
            rsp_data_q <= (!range_err && !write_q) ? (bus.mem_data_rd & width_mask(width_q)) : '0;
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Checks memory_arbiter against a transaction-level model: arbitration rules,
// two-cycle access timing, byte-addressed reference memory and range errors.
module tb_memory_arbiter;
   import memory_access_width::*;
   import memory_arbiter_pkg::*;

   localparam int BYTES  = 64000;
   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   memory_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   memory_arbiter #(.BYTES(BYTES), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      mem_requester_t       src;
      logic [31:0]          addr;
      memory_access_width_t width;
      bit                   write;
      logic [31:0]          data;
   } txn_t;

   logic [7:0] mem     [BYTES];
   logic [7:0] ref_mem [BYTES];

   int total = 0;
   int bad   = 0;

   bit             m_acc_v, m_rsp_v, m_rsp_err;
   txn_t           m_acc;
   mem_requester_t m_last, m_rsp_src;
   logic [31:0]    m_rsp_data;

   bit          if_acc, ls_acc, obs_if_rdy, obs_ls_rdy;
   int          if_rsp_cnt, ls_rsp_cnt, cycle;
   logic [31:0] last_if_data, last_ls_data;
   logic        last_ls_err;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int nbytes_of(memory_access_width_t w);
      return (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
   endfunction

   function automatic bit out_of_range(logic [31:0] a, memory_access_width_t w);
      logic [63:0] e;
      e = {32'b0, a} + 64'(nbytes_of(w));
      return e > 64'(BYTES);
   endfunction

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)  return 32'($urandom_range(0, 63));
      if (r == 7) return 32'(BYTES - $urandom_range(0, 6));
      if (r == 8) return 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      return 32'($urandom_range(0, BYTES - 1));
   endfunction

   // One clock: check outputs at the falling edge, advance the model, serve the memory.
   task automatic applyStimulus();
      bit          err, exp_if, exp_ls;
      int          nb;
      logic [31:0] rdata, mask, rd;
      longint      a;
      @(negedge clk);
      cycle++;
      err = 1'b0;
      rdata = '0;
      exp_if = 1'b0;
      exp_ls = 1'b0;
      obs_if_rdy = bus.if_req_ready;
      obs_ls_rdy = bus.ls_req_ready;
      if (bus.if_rsp_valid) begin
         if_rsp_cnt++;
         last_if_data = bus.if_rsp_data;
      end
      if (bus.ls_rsp_valid) begin
         ls_rsp_cnt++;
         last_ls_data = bus.ls_rsp_data;
         last_ls_err  = bus.ls_rsp_err;
      end
      if (!rst_n) begin
         checkOutput("rst_if_ready", bus.if_req_ready, 0);
         checkOutput("rst_ls_ready", bus.ls_req_ready, 0);
         checkOutput("rst_if_rsp", {bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data}, 0);
         checkOutput("rst_ls_rsp", {bus.ls_rsp_valid, bus.ls_rsp_err, bus.ls_rsp_data}, 0);
         checkOutput("rst_mem_en", {bus.mem_rd_en, bus.mem_wr_en}, 0);
         checkOutput("rst_mem_bus", {bus.mem_addr, bus.mem_data_wr}, 0);
         checkOutput("rst_mem_width", bus.mem_width, 0);
         m_acc_v = 1'b0;
         m_rsp_v = 1'b0;
         m_last  = LS;
      end else begin
         checkOutput("if_rsp_valid", bus.if_rsp_valid, m_rsp_v && m_rsp_src == IF);
         checkOutput("ls_rsp_valid", bus.ls_rsp_valid, m_rsp_v && m_rsp_src == LS);
         if (m_rsp_v && m_rsp_src == IF) begin
            checkOutput("if_rsp_err", bus.if_rsp_err, m_rsp_err);
            if (!m_rsp_err) checkOutput("if_rsp_data", bus.if_rsp_data, m_rsp_data);
         end
         if (m_rsp_v && m_rsp_src == LS) begin
            checkOutput("ls_rsp_err", bus.ls_rsp_err, m_rsp_err);
            if (!m_rsp_err) checkOutput("ls_rsp_data", bus.ls_rsp_data, m_rsp_data);
         end
         if (m_acc_v) begin
            err = out_of_range(m_acc.addr, m_acc.width);
            nb  = nbytes_of(m_acc.width);
            mask = 32'((64'd1 << (8 * nb)) - 64'd1);
            checkOutput("mem_rd_en", bus.mem_rd_en, !err && !m_acc.write);
            checkOutput("mem_wr_en", bus.mem_wr_en, !err && m_acc.write);
            if (!err) begin
               checkOutput("mem_addr", bus.mem_addr, m_acc.addr);
               checkOutput("mem_width", bus.mem_width, m_acc.width);
               if (m_acc.write) checkOutput("mem_data_wr", bus.mem_data_wr & mask, m_acc.data & mask);
               for (int i = 0; i < nb; i++) begin
                  if (m_acc.write) ref_mem[int'(m_acc.addr) + i] = m_acc.data[8*i +: 8];
                  else rdata[8*i +: 8] = ref_mem[int'(m_acc.addr) + i];
               end
            end
         end else begin
            checkOutput("mem_en_idle", {bus.mem_rd_en, bus.mem_wr_en}, 0);
            checkOutput("mem_addr_idle", bus.mem_addr, 0);
         end
         exp_if = !m_acc_v && bus.if_req_valid && (!bus.ls_req_valid || m_last == LS);
         exp_ls = !m_acc_v && bus.ls_req_valid && (!bus.if_req_valid || m_last == IF);
         checkOutput("if_req_ready", bus.if_req_ready, exp_if);
         checkOutput("ls_req_ready", bus.ls_req_ready, exp_ls);
         m_rsp_v    = m_acc_v;
         m_rsp_src  = m_acc.src;
         m_rsp_data = rdata;
         m_rsp_err  = err;
         m_acc_v    = exp_if || exp_ls;
         if (exp_if) begin
            m_acc  = '{IF, bus.if_req_addr, WORD, 1'b0, 32'h0};
            m_last = IF;
         end else if (exp_ls) begin
            m_acc  = '{LS, bus.ls_req_addr, bus.ls_req_width, bus.ls_req_write, bus.ls_req_data};
            m_last = LS;
         end
      end
      if_acc = exp_if;
      ls_acc = exp_ls;
      if (bus.mem_wr_en) begin
         for (int i = 0; i < nbytes_of(bus.mem_width); i++) begin
            a = longint'({32'b0, bus.mem_addr}) + i;
            if (a < BYTES) mem[int'(a)] = bus.mem_data_wr[8*i +: 8];
         end
      end
      rd = '0;
      for (int i = 0; i < 4; i++) begin
         a = longint'({32'b0, bus.mem_addr}) + i;
         if (a < BYTES) rd[8*i +: 8] = mem[int'(a)];
      end
      bus.mem_data_rd = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic lsOp(input bit wr, input memory_access_width_t w, input logic [31:0] addr,
                       input logic [31:0] data);
      bit done;
      done = 1'b0;
      bus.ls_req_valid = 1'b1;
      bus.ls_req_write = wr;
      bus.ls_req_width = w;
      bus.ls_req_addr  = addr;
      bus.ls_req_data  = data;
      for (int k = 0; k < 10 && !done; k++) begin
         applyStimulus();
         done = ls_acc;
      end
      if (!done) checkOutput("ls_accept_timeout", 0, 1);
      bus.ls_req_valid = 1'b0;
      applyStimulus();
      applyStimulus();
   endtask

   task automatic newLsReq(input bit reads_only);
      bus.ls_req_valid = 1'b1;
      bus.ls_req_write = reads_only ? 1'b0 : 1'($urandom_range(0, 1));
      bus.ls_req_width = memory_access_width_t'($urandom_range(0, 2));
      bus.ls_req_addr  = reads_only ? 32'($urandom_range(0, 255)) : rand_addr();
      bus.ls_req_data  = $urandom;
   endtask

   initial begin
      int          accepts, prev_cycle, if_before, ls_before;
      mem_requester_t seq [8];
      for (int i = 0; i < BYTES; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      {mem[259], mem[258], mem[257], mem[256]} = 32'hDEADBEEF;
      {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]} = 32'hDEADBEEF;
      m_last = LS;
      cycle = 0;
      if_rsp_cnt = 0;
      ls_rsp_cnt = 0;
      last_ls_err = 1'b0;
      bus.mem_data_rd  = '0;
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h100;
      bus.ls_req_valid = 1'b1;
      bus.ls_req_write = 1'b0;
      bus.ls_req_width = WORD;
      bus.ls_req_addr  = 32'h104;
      bus.ls_req_data  = 32'h0;

      $display("[TB] reset with both requesters valid");
      repeat (3) applyStimulus();
      rst_n = 1'b1;
      applyStimulus();
      checkOutput("first_grant_if", obs_if_rdy, 1);
      checkOutput("first_grant_ls_blocked", obs_ls_rdy, 0);
      if (if_acc) bus.if_req_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus();
         if (if_acc) bus.if_req_valid = 1'b0;
         if (ls_acc) bus.ls_req_valid = 1'b0;
      end
      checkOutput("fetch_data", last_if_data, 32'hDEADBEEF);
      checkOutput("fetch_count", if_rsp_cnt, 1);

      $display("[TB] continuous conflict for 8 accesses");
      if_before = if_rsp_cnt;
      ls_before = ls_rsp_cnt;
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'($urandom_range(0, 255));
      newLsReq(1'b1);
      accepts = 0;
      prev_cycle = 0;
      for (int k = 0; k < 40 && accepts < 8; k++) begin
         applyStimulus();
         if ((obs_if_rdy && bus.if_req_valid) || (obs_ls_rdy && bus.ls_req_valid)) begin
            seq[accepts] = obs_if_rdy ? IF : LS;
            if (accepts > 0) checkOutput("accept_spacing", cycle - prev_cycle, 2);
            prev_cycle = cycle;
            accepts++;
         end
         if (if_acc) bus.if_req_addr = 32'($urandom_range(0, 255));
         if (ls_acc) newLsReq(1'b1);
      end
      checkOutput("conflict_accepts", accepts, 8);
      for (int k = 0; k < accepts; k++) checkOutput("alternate", seq[k], (k % 2 == 0) ? IF : LS);
      bus.if_req_valid = 1'b0;
      bus.ls_req_valid = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("conflict_if_rsps", if_rsp_cnt - if_before, 4);
      checkOutput("conflict_ls_rsps", ls_rsp_cnt - ls_before, 4);

      $display("[TB] directed load/store cases");
      lsOp(1'b1, BYTE, 32'h13, 32'h0000_00A5);
      lsOp(1'b0, WORD, 32'h10, 32'h0);
      checkOutput("word_after_byte", last_ls_data, 32'hA500_0000);
      lsOp(1'b0, HALF, 32'h12, 32'h0);
      checkOutput("half_read", last_ls_data, 32'h0000_A500);
      lsOp(1'b0, WORD, 32'(BYTES - 2), 32'h0);
      checkOutput("err_top", last_ls_err, 1);
      lsOp(1'b0, WORD, 32'hFFFF_FFFE, 32'h0);
      checkOutput("err_wrap", last_ls_err, 1);

      $display("[TB] reset during write access");
      ls_before = ls_rsp_cnt;
      bus.ls_req_valid = 1'b1;
      bus.ls_req_write = 1'b1;
      bus.ls_req_width = WORD;
      bus.ls_req_addr  = 32'h20;
      bus.ls_req_data  = 32'h1234_5678;
      ls_acc = 1'b0;
      for (int k = 0; k < 10 && !ls_acc; k++) applyStimulus();
      bus.ls_req_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) applyStimulus();
      rst_n = 1'b1;
      repeat (2) applyStimulus();
      checkOutput("no_rsp_after_reset", ls_rsp_cnt - ls_before, 0);
      lsOp(1'b0, WORD, 32'h20, 32'h0);
      checkOutput("write_suppressed", last_ls_data, 32'h0);

      $display("[TB] randomized traffic");
      for (int k = 0; k < 500; k++) begin
         applyStimulus();
         if (if_acc || !bus.if_req_valid) begin
            bus.if_req_valid = ($urandom_range(0, 9) < 6);
            bus.if_req_addr  = rand_addr();
         end else if ($urandom_range(0, 15) == 0) begin
            bus.if_req_valid = 1'b0;
         end
         if (ls_acc || !bus.ls_req_valid) begin
            if ($urandom_range(0, 9) < 6) newLsReq(1'b0);
            else bus.ls_req_valid = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            bus.ls_req_valid = 1'b0;
         end
      end
      bus.if_req_valid = 1'b0;
      bus.ls_req_valid = 1'b0;
      repeat (3) applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
